// File: rtl/exu_stage.sv
`default_nettype none
//----------------------------------------------------------------------------
// exu_stage: execute-stage register with operand select, write-back and redirect
// Revision: 1.0
//----------------------------------------------------------------------------
module exu_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ARGS_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_flush,
   input  logic                  i_id_valid,
   output logic                  o_id_ready,
   input  logic [ARGS_WIDTH-1:0] i_id_alu_type,
   input  logic [DATA_WIDTH-1:0] i_id_rs1_data,
   input  logic [DATA_WIDTH-1:0] i_id_rs2_data,
   input  logic [DATA_WIDTH-1:0] i_id_pc,
   input  logic [DATA_WIDTH-1:0] i_id_imm,
   input  logic                  i_id_src1_sel,
   input  logic                  i_id_src2_sel,
   input  logic [4:0]            i_id_rd_addr,
   input  logic                  i_id_rd_wen,
   input  logic                  i_id_is_br,
   input  logic                  i_id_is_jal,
   input  logic                  i_id_is_jalr,
   output logic [ARGS_WIDTH-1:0] o_alu_type,
   output logic [DATA_WIDTH-1:0] o_alu_rs1_data,
   output logic [DATA_WIDTH-1:0] o_alu_rs2_data,
   input  logic [DATA_WIDTH-1:0] i_alu_res,
   output logic                  o_ex_valid,
   input  logic                  i_ex_ready,
   output logic [DATA_WIDTH-1:0] o_ex_res,
   output logic [4:0]            o_ex_rd_addr,
   output logic                  o_ex_rd_wen,
   output logic                  o_redirect,
   output logic [DATA_WIDTH-1:0] o_redirect_pc
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   logic                  valid;
   logic [ARGS_WIDTH-1:0] alu_type;
   logic [DATA_WIDTH-1:0] op1;
   logic [DATA_WIDTH-1:0] op2;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] imm;
   logic [4:0]            rd_addr;
   logic                  rd_wen;
   logic                  is_br;
   logic                  is_jal;
   logic                  is_jalr;

   logic                  accept;
   logic                  fire;
   logic                  taken;
   logic                  redirect;

   assign o_id_ready = !valid || i_ex_ready;
   assign accept     = i_id_valid && o_id_ready;
   assign fire       = valid && i_ex_ready;
   assign taken      = is_jal || is_jalr || (is_br && i_alu_res[0]);
   assign redirect   = fire && taken;

   // Payload only moves on accept, which also keeps everything stable while stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         alu_type <= '0;
         op1      <= '0;
         op2      <= '0;
         pc       <= '0;
         imm      <= '0;
         rd_addr  <= '0;
         rd_wen   <= 1'b0;
         is_br    <= 1'b0;
         is_jal   <= 1'b0;
         is_jalr  <= 1'b0;
      end else if (accept) begin
         alu_type <= i_id_alu_type;
         op1      <= i_id_src1_sel ? i_id_pc  : i_id_rs1_data;
         op2      <= i_id_src2_sel ? i_id_imm : i_id_rs2_data;
         pc       <= i_id_pc;
         imm      <= i_id_imm;
         rd_addr  <= i_id_rd_addr;
         rd_wen   <= i_id_rd_wen;
         is_br    <= i_id_is_br;
         is_jal   <= i_id_is_jal;
         is_jalr  <= i_id_is_jalr;
      end
   end

   // A taken redirect also kills whatever ID handed over in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid <= 1'b0;
      end else if (i_flush) begin
         valid <= 1'b0;
      end else if (redirect) begin
         valid <= 1'b0;
      end else if (accept) begin
         valid <= 1'b1;
      end else if (fire) begin
         valid <= 1'b0;
      end
   end

   assign o_alu_type     = alu_type;
   assign o_alu_rs1_data = op1;
   assign o_alu_rs2_data = op2;

   assign o_ex_valid    = valid;
   assign o_ex_res      = (is_jal || is_jalr) ? (pc + PC_STEP) : i_alu_res;
   assign o_ex_rd_addr  = rd_addr;
   assign o_ex_rd_wen   = rd_wen && !is_br;
   assign o_redirect    = redirect;
   assign o_redirect_pc = !redirect ? '0 : (is_jalr ? i_alu_res : (pc + imm));

endmodule
`default_nettype wire
